// File: rtl/audio_clk_pkg.sv
// Shared types and helpers for the audio clock-enable generator.
package audio_clk_pkg;

  typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} state_t;

  localparam int DIV_W_DEF = 16;
  localparam int DIV_MIN   = 2;

  typedef logic [DIV_W_DEF-1:0] div_t;

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/audio_clkdiv_chan.sv
// One divided output: wrap counter, registered square wave and rising-edge enable.
module audio_clkdiv_chan
  import audio_clk_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             align,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] ld,
  output logic             outclk,
  output logic             outclk_ce
);

  logic [DIV_W-1:0] cnt, nxt, half;

  // Outputs are registered from the count they accompany, so they line up with cnt.
  always_comb begin
    half = (div >> 1) + {{(DIV_W-1){1'b0}}, div[0]};
    if (align)                   nxt = ld;
    else if (cnt == div - 1'b1)  nxt = '0;
    else                         nxt = cnt + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt       <= '0;
      outclk    <= 1'b0;
      outclk_ce <= 1'b0;
    end else if (hold) begin
      outclk    <= 1'b0;
      outclk_ce <= 1'b0;
    end else begin
      cnt       <= nxt;
      outclk    <= (nxt < half);
      outclk_ce <= (nxt == '0);
    end
  end

endmodule

// File: rtl/audio_clkdiv_gen.sv
// Reprogrammable audio clock-enable generator: shadow/active ratios, commit, lock FSM.
// Optional per-output phase offsets when AUDIO_CLKGEN_PHASE_EN is defined.
module audio_clkdiv_gen
  import audio_clk_pkg::*;
#(
  parameter int                        NUM_CLKS    = 3,
  parameter int                        DIV_W       = 16,
  parameter int                        LOCK_CYCLES = 256,
  parameter logic [NUM_CLKS*DIV_W-1:0] DIV_INIT    = {16'd8, 16'd4, 16'd2}
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_phase,
  input  logic                cfg_commit,
  output logic                cfg_err,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] outclk_ce,
  output logic                locked
);

  localparam int SW = $clog2(LOCK_CYCLES + 1);

  state_t                             state;
  logic [SW-1:0]                      settle;
  logic [NUM_CLKS-1:0][DIV_W-1:0]     shadow, shadow_nxt, active, act_nxt, ld;
  logic                               wr_acc, sel_ok, commit_ok;

  assign wr_acc    = cfg_valid && cfg_ready;
  assign sel_ok    = int'(cfg_sel) < NUM_CLKS;
  assign commit_ok = cfg_commit && (state != ALIGN);

  // A write in the commit cycle lands first, so the commit carries it.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NUM_CLKS; i++) begin
      if (wr_acc && sel_ok && int'(cfg_sel) == i) shadow_nxt[i] = cfg_div;
      act_nxt[i] = DIV_W'(clamp_div(32'(shadow_nxt[i])));
    end
  end

`ifdef AUDIO_CLKGEN_PHASE_EN
  logic [NUM_CLKS-1:0][DIV_W-1:0] phase, phase_nxt, ld_nxt;

  // Single conditional subtraction: phase is expected below twice the ratio.
  always_comb begin
    phase_nxt = phase;
    for (int i = 0; i < NUM_CLKS; i++) begin
      if (wr_acc && sel_ok && int'(cfg_sel) == i) phase_nxt[i] = cfg_phase;
      ld_nxt[i] = (phase_nxt[i] >= act_nxt[i]) ? phase_nxt[i] - act_nxt[i] : phase_nxt[i];
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      phase <= '0;
      ld    <= '0;
    end else begin
      phase <= phase_nxt;
      if (commit_ok) ld <= ld_nxt;
    end
  end
`else
  logic unused_phase;
  assign unused_phase = ^cfg_phase;
  assign ld           = '0;
`endif

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= ALIGN;
      settle    <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      shadow    <= DIV_INIT;
      active    <= DIV_INIT;
    end else begin
      cfg_err <= wr_acc && !sel_ok;
      shadow  <= shadow_nxt;
      case (state)
        ALIGN: begin
          state     <= SETTLE;
          settle    <= '0;
          cfg_ready <= 1'b1;
        end
        SETTLE, LOCKED: begin
          if (commit_ok) begin
            state     <= ALIGN;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            active    <= act_nxt;
          end else if (state == SETTLE) begin
            settle <= settle + 1'b1;
            if (settle == SW'(LOCK_CYCLES - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
        default: state <= ALIGN;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chan
    audio_clkdiv_chan #(.DIV_W(DIV_W)) u_chan (
      .refclk    (refclk),
      .rst       (rst),
      .align     (state == ALIGN),
      .hold      (commit_ok),
      .div       (active[g]),
      .ld        (ld[g]),
      .outclk    (outclk[g]),
      .outclk_ce (outclk_ce[g])
    );
  end

endmodule

// File: tb/tb_audio_clkdiv_gen.sv
// Randomised and directed bench for audio_clkdiv_gen against a cycles-since-align model.
module tb_audio_clkdiv_gen;

  localparam int N = 3;
  localparam int L = 16;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0, cfg_commit = 1'b0;
  logic [2:0]  cfg_sel = '0;
  logic [15:0] cfg_div = '0, cfg_phase = '0;
  logic        cfg_ready, cfg_err, locked;
  logic [N-1:0] outclk, outclk_ce;

  int npass = 0, ntotal = 0;

  // Model: ratios/phases in force, and cycles elapsed since the ALIGN cycle (0 = ALIGN).
  int m_sh[N], m_act[N], m_psh[N], m_p[N], m_t;
  bit m_err;

  always #5 refclk = ~refclk;

  audio_clkdiv_gen #(.NUM_CLKS(N), .DIV_W(16), .LOCK_CYCLES(L)) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_commit(cfg_commit),
    .cfg_err(cfg_err), .outclk(outclk), .outclk_ce(outclk_ce), .locked(locked)
  );

  function automatic logic [N-1:0] e_clk();
    logic [N-1:0] r = '0;
    if (m_t == 0) return r;
    for (int i = 0; i < N; i++) r[i] = (((m_t - 1 + m_p[i]) % m_act[i]) < (m_act[i] + 1) / 2);
    return r;
  endfunction

  function automatic logic [N-1:0] e_ce();
    logic [N-1:0] r = '0;
    if (m_t == 0) return r;
    for (int i = 0; i < N; i++) r[i] = (((m_t - 1 + m_p[i]) % m_act[i]) == 0);
    return r;
  endfunction

  // Drive one cycle of inputs, take the edge, update the model, settle #1 past the edge.
  task automatic step(input bit r, input bit v, input int s, input int d, input int ph, input bit c);
    bit rdy;
    rst = r; cfg_valid = v; cfg_sel = 3'(s); cfg_div = 16'(d); cfg_phase = 16'(ph); cfg_commit = c;
    @(posedge refclk);
    if (r) begin
      m_sh = '{2, 4, 8}; m_act = '{2, 4, 8}; m_psh = '{0, 0, 0}; m_p = '{0, 0, 0};
      m_t = 0; m_err = 0;
    end else begin
      rdy = (m_t >= 1);
      m_err = 0;
      if (v && rdy) begin
        if (s < N) begin
          m_sh[s] = d;
`ifdef AUDIO_CLKGEN_PHASE_EN
          m_psh[s] = ph;
`endif
        end else m_err = 1;
      end
      if (c && rdy) begin
        for (int i = 0; i < N; i++) begin
          m_act[i] = (m_sh[i] < 2) ? 2 : m_sh[i];
          m_p[i]   = m_psh[i] % m_act[i];
        end
        m_t = 0;
      end else m_t++;
    end
    #1;
    rst = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    ntotal++;
    if ({outclk, outclk_ce, locked, cfg_ready, cfg_err} !== '0) begin
      $display("FAIL reset_state clk=%b ce=%b lock=%b rdy=%b err=%b want all 0",
               outclk, outclk_ce, locked, cfg_ready, cfg_err);
    end else npass++;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      step(0, 0, 0, 0, 0, 0);
      ntotal++;
      if (outclk !== e_clk() || outclk_ce !== e_ce() || locked !== (cyc >= L + 1) || cfg_ready !== 1'b1) begin
        $display("FAIL reset_run cyc=%0d clk=%b/%b ce=%b/%b lock=%b/%b rdy=%b",
                 cyc, outclk, e_clk(), outclk_ce, e_ce(), locked, cyc >= L + 1, cfg_ready);
      end else npass++;
      if (cyc == 1) begin
        ntotal++;
        if (outclk_ce !== 3'b111 || outclk !== 3'b111)
          $display("FAIL first_settle_align ce=%b clk=%b want 111/111", outclk_ce, outclk);
        else npass++;
      end
    end
  endtask

  task automatic test_write_no_commit();
    step(0, 1, 1, 5, 0, 0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(0, 0, 0, 0, 0, 0);
      ntotal++;
      if (outclk !== e_clk() || outclk_ce !== e_ce() || locked !== 1'b1 || cfg_err !== 1'b0) begin
        $display("FAIL write_no_commit k=%0d clk=%b/%b ce=%b/%b lock=%b want 1 err=%b",
                 k, outclk, e_clk(), outclk_ce, e_ce(), locked, cfg_err);
      end else npass++;
    end
  endtask

  task automatic test_commit();
    int highs = 0;
    step(0, 0, 0, 0, 0, 1);
    ntotal++;
    if (locked !== 1'b0 || cfg_ready !== 1'b0 || outclk !== '0)
      $display("FAIL commit_drop lock=%b rdy=%b clk=%b want 0/0/000", locked, cfg_ready, outclk);
    else npass++;
    for (int t = 1; t <= 22; t++) begin
      step(0, 0, 0, 0, 0, 0);
      if (t <= 5) highs += int'(outclk[1]);
      ntotal++;
      if (outclk !== e_clk() || outclk_ce !== e_ce() || locked !== (t >= L + 1)) begin
        $display("FAIL commit_run t=%0d clk=%b/%b ce=%b/%b lock=%b/%b",
                 t, outclk, e_clk(), outclk_ce, e_ce(), locked, t >= L + 1);
      end else npass++;
    end
    ntotal++;
    if (highs !== 3) $display("FAIL div5_duty highs=%0d want 3", highs);
    else npass++;
  endtask

  task automatic test_clamp();
    step(0, 1, 2, 0, 0, 1);
    for (int t = 1; t <= 10; t++) begin
      step(0, 0, 0, 0, 0, 0);
      ntotal++;
      if (outclk[2] !== t[0] || outclk !== e_clk() || outclk_ce !== e_ce()) begin
        $display("FAIL clamp_div0 t=%0d clk=%b/%b ce=%b/%b bit2 want %b",
                 t, outclk, e_clk(), outclk_ce, e_ce(), t[0]);
      end else npass++;
    end
  endtask

  task automatic test_bad_sel();
    step(0, 1, 5, 7, 0, 0);
    ntotal++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1)
      $display("FAIL bad_sel_err err=%b rdy=%b want 1/1", cfg_err, cfg_ready);
    else npass++;
    step(0, 0, 0, 0, 0, 0);
    ntotal++;
    if (cfg_err !== 1'b0) $display("FAIL bad_sel_pulse err=%b want 0", cfg_err);
    else npass++;
    // Shadows must still be (2,5,0->2) after the dropped write.
    step(0, 0, 0, 0, 0, 1);
    for (int t = 1; t <= 12; t++) begin
      step(0, 0, 0, 0, 0, 0);
      ntotal++;
      if (outclk !== e_clk() || outclk_ce !== e_ce() || cfg_ready !== 1'b1) begin
        $display("FAIL bad_sel_shadow t=%0d clk=%b/%b ce=%b/%b rdy=%b",
                 t, outclk, e_clk(), outclk_ce, e_ce(), cfg_ready);
      end else npass++;
    end
  endtask

  task automatic test_commit_settle();
    step(0, 1, 0, 6, 0, 1);
    for (int t = 1; t <= 10; t++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int t = 1; t <= 20; t++) begin
      step(0, 0, 0, 0, 0, 0);
      ntotal++;
      if (locked !== (t >= L + 1) || outclk !== e_clk() || outclk_ce !== e_ce()) begin
        $display("FAIL commit_in_settle t=%0d lock=%b/%b clk=%b/%b ce=%b/%b",
                 t, locked, t >= L + 1, outclk, e_clk(), outclk_ce, e_ce());
      end else npass++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      step(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 15) == 0) ? 16'hffff : int'($urandom_range(0, 9)),
           int'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
      ntotal++;
      if (outclk !== e_clk() || outclk_ce !== e_ce() || locked !== (m_t >= L + 1) ||
          cfg_ready !== (m_t >= 1) || cfg_err !== m_err) begin
        $display("FAIL random k=%0d clk=%b/%b ce=%b/%b lock=%b/%b rdy=%b/%b err=%b/%b",
                 k, outclk, e_clk(), outclk_ce, e_ce(), locked, m_t >= L + 1,
                 cfg_ready, m_t >= 1, cfg_err, m_err);
      end else npass++;
    end
  endtask

`ifdef AUDIO_CLKGEN_PHASE_EN
  task automatic test_phase();
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 4, 0, 0);
    step(0, 1, 2, 2, 0, 0);
    step(0, 1, 0, 8, 3, 1);
    for (int t = 1; t <= 14; t++) begin
      step(0, 0, 0, 0, 0, 0);
      ntotal++;
      if (outclk_ce[0] !== (t == 6 || t == 14) || outclk_ce[2:1] !== ((t == 1) ? 2'b11 : e_ce() >> 1) ||
          outclk !== e_clk()) begin
        $display("FAIL phase t=%0d ce=%b/%b clk=%b/%b", t, outclk_ce, e_ce(), outclk, e_clk());
      end else npass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_no_commit();
    test_commit();
    test_clamp();
    test_bad_sel();
    test_commit_settle();
    test_random();
`ifdef AUDIO_CLKGEN_PHASE_EN
    test_phase();
`endif
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
